// File: rtl/sram_hs.sv
// sram_hs: handshaked single-ported behavioural SRAM with valid/ready read and write channels.
// Optional macro SRAM_RAND_DELAY_EN adds 0..3 cycles of LFSR-driven latency per request.
//
// Ports:
//   clk, rst                      clock; asynchronous active-high reset
//   rd_req_valid/ready, rd_addr   read request channel
//   rd_resp_valid/ready, rd_data  read response channel (data held until taken)
//   wr_req_valid/ready, wr_addr,
//   wr_data, wr_mask              write request channel (mask[3:0] are byte enables)
//   wr_resp_valid/ready           write acknowledge channel
//
// The backing store is a word array reached only through n_pmem_read and n_pmem_write.
// Each is used once per accepted request, on the edge that enters the response state.
// Only address bits [MEM_AW+1:2] index the store; the rest are ignored.
module sram_hs #(
  parameter int ADDR_W    = 32,
  parameter int READ_LAT  = 1,
  parameter int WRITE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_resp_valid,
  input  logic              rd_resp_ready,
  output logic [31:0]       rd_data,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [7:0]        wr_mask,
  output logic              wr_resp_valid,
  input  logic              wr_resp_ready
);

  localparam int MEM_AW    = 8;
  localparam int MEM_WORDS = 1 << MEM_AW;

  if (READ_LAT < 1 || READ_LAT > 15) begin : g_bad_rd_lat
    $fatal(1, "sram_hs: READ_LAT must be in 1..15");
  end
  if (WRITE_LAT < 1 || WRITE_LAT > 15) begin : g_bad_wr_lat
    $fatal(1, "sram_hs: WRITE_LAT must be in 1..15");
  end

  localparam logic [5:0] RD_BASE = 6'(READ_LAT - 1);
  localparam logic [5:0] WR_BASE = 6'(WRITE_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_WR_WAIT,
    S_RD_RESP,
    S_WR_RESP
  } state_t;

  localparam logic GNT_RD = 1'b0;
  localparam logic GNT_WR = 1'b1;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  mask_q, mask_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [31:0] mem_q [MEM_WORDS];

  logic        idle;
  logic        grant_rd;
  logic        grant_wr;
  logic        accept;
  logic        cnt_zero;
  logic        wr_commit;
  logic [5:0]  extra;

  function automatic logic [MEM_AW-1:0] word_idx(input logic [31:0] a);
    return a[MEM_AW+1:2];
  endfunction

  function automatic logic [31:0] n_pmem_read(input logic [31:0] a);
    return mem_q[word_idx({a[31:2], 2'b00})];
  endfunction

  // Returns the merged word to store; bytes without an enable keep old data.
  function automatic logic [31:0] n_pmem_write(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [7:0]  m
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  assign idle     = (state_q == S_IDLE);
  assign cnt_zero = (cnt_q == 6'd0);

  // Alternating priority only matters when both channels request at once.
  assign grant_rd = idle & rd_req_valid
                  & (~wr_req_valid | (last_grant_q == GNT_WR));
  assign grant_wr = idle & wr_req_valid & ~grant_rd;
  assign accept   = grant_rd | grant_wr;

  assign wr_commit = (state_q == S_WR_WAIT) & cnt_zero;

`ifdef SRAM_RAND_DELAY_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic       lfsr_fb;

  // x^8 + x^6 + x^5 + x^4 + 1
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign lfsr_d  = accept ? {lfsr_q[6:0], lfsr_fb} : lfsr_q;
  assign extra   = {4'd0, lfsr_q[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= lfsr_d;
  end
`else
  assign extra = 6'd0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    data_d       = data_q;
    mask_d       = mask_q;
    rd_data_d    = rd_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_rd) begin
          addr_d       = 32'(rd_addr);
          cnt_d        = RD_BASE + extra;
          last_grant_d = GNT_RD;
          state_d      = S_RD_WAIT;
        end else if (grant_wr) begin
          addr_d       = 32'(wr_addr);
          data_d       = wr_data;
          mask_d       = wr_mask;
          cnt_d        = WR_BASE + extra;
          last_grant_d = GNT_WR;
          state_d      = S_WR_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (cnt_zero) begin
          rd_data_d = n_pmem_read(addr_q);
          state_d   = S_RD_RESP;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      S_WR_WAIT: begin
        if (cnt_zero) state_d = S_WR_RESP;
        else          cnt_d   = cnt_q - 6'd1;
      end
      S_RD_RESP: begin
        if (rd_resp_ready) state_d = S_IDLE;
      end
      S_WR_RESP: begin
        if (wr_resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 6'd0;
      last_grant_q <= GNT_WR;
      addr_q       <= 32'd0;
      data_q       <= 32'd0;
      mask_q       <= 8'd0;
      rd_data_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      mask_q       <= mask_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Storage is deliberately not reset: committed writes survive rst.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      mem_q[word_idx(addr_q)] <=
        n_pmem_write(mem_q[word_idx(addr_q)], data_q, mask_q);
    end
  end

  assign rd_req_ready  = idle;
  assign wr_req_ready  = idle;
  assign rd_resp_valid = (state_q == S_RD_RESP);
  assign wr_resp_valid = (state_q == S_WR_RESP);
  assign rd_data       = rd_data_q;

  logic unused_bits;
  assign unused_bits = ^{addr_q[31:MEM_AW+2], addr_q[1:0], mask_q[7:4]};

endmodule

// File: tb/tb_sram_hs.sv
// tb_sram_hs: directed self-checking bench for sram_hs.
// READ_LAT=1, WRITE_LAT=3; covers grants, stalls, masked writes and reset mid-write.
module tb_sram_hs;

  localparam int RL = 1;
  localparam int WL = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req_valid, rd_req_ready;
  logic [31:0] rd_addr;
  logic        rd_resp_valid, rd_resp_ready;
  logic [31:0] rd_data;
  logic        wr_req_valid, wr_req_ready;
  logic [31:0] wr_addr, wr_data;
  logic [7:0]  wr_mask;
  logic        wr_resp_valid, wr_resp_ready;

  int vecs = 0;
  int errs = 0;

  sram_hs #(
    .ADDR_W   (32),
    .READ_LAT (RL),
    .WRITE_LAT(WL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_addr      (rd_addr),
    .rd_resp_valid(rd_resp_valid),
    .rd_resp_ready(rd_resp_ready),
    .rd_data      (rd_data),
    .wr_req_valid (wr_req_valid),
    .wr_req_ready (wr_req_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_mask      (wr_mask),
    .wr_resp_valid(wr_resp_valid),
    .wr_resp_ready(wr_resp_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_lat(input string tag, input int n, input int lat);
`ifdef SRAM_RAND_DELAY_EN
    chk(tag, 32'(n >= lat && n <= lat + 3), 32'd1);
`else
    chk(tag, 32'(n), 32'(lat));
`endif
  endtask

  task automatic wait_rd(output int n);
    n = 0;
    while (!rd_resp_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_wr(output int n);
    n = 0;
    while (!wr_resp_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [7:0] m, input string tag);
    int n;
    chk({tag, " wr_ready"}, 32'(wr_req_ready), 32'd1);
    wr_addr      = a;
    wr_data      = d;
    wr_mask      = m;
    wr_req_valid = 1'b1;
    tick();
    wr_req_valid = 1'b0;
    wait_wr(n);
    chk_lat({tag, " wr_lat"}, n, WL);
    tick();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp,
                         input string tag);
    int n;
    chk({tag, " rd_ready"}, 32'(rd_req_ready), 32'd1);
    rd_addr      = a;
    rd_req_valid = 1'b1;
    tick();
    rd_req_valid = 1'b0;
    wait_rd(n);
    chk_lat({tag, " rd_lat"}, n, RL);
    chk({tag, " rd_data"}, rd_data, exp);
    tick();
  endtask

  initial begin
    int n;
    rst           = 1'b1;
    rd_req_valid  = 1'b0;
    rd_addr       = 32'd0;
    rd_resp_ready = 1'b1;
    wr_req_valid  = 1'b0;
    wr_addr       = 32'd0;
    wr_data       = 32'd0;
    wr_mask       = 8'd0;
    wr_resp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    chk("rst rd_resp_valid", 32'(rd_resp_valid), 32'd0);
    chk("rst wr_resp_valid", 32'(wr_resp_valid), 32'd0);
    chk("rst rd_data", rd_data, 32'd0);

    // Preload, then an unaligned read returns the aligned word.
    do_write(32'h8000_0000, 32'hDEAD_BEEF, 8'h0F, "pre0");
    do_read(32'h8000_0002, 32'hDEAD_BEEF, "t1");

    // Write commits exactly on the response-entering edge.
    do_write(32'h8000_0010, 32'h0000_0000, 8'h0F, "pre4");
    wr_addr      = 32'h8000_0010;
    wr_data      = 32'h1234_5678;
    wr_mask      = 8'h0F;
    wr_req_valid = 1'b1;
    tick();
    wr_req_valid = 1'b0;
`ifndef SRAM_RAND_DELAY_EN
    tick();
    tick();
    chk("t2 mem T+2", dut.mem_q[4], 32'h0000_0000);
    chk("t2 resp T+2", 32'(wr_resp_valid), 32'd0);
    tick();
    chk("t2 mem T+3", dut.mem_q[4], 32'h1234_5678);
    chk("t2 resp T+3", 32'(wr_resp_valid), 32'd1);
`else
    wait_wr(n);
    chk_lat("t2 wr_lat", n, WL);
`endif
    tick();
    do_read(32'h8000_0010, 32'h1234_5678, "t2rb");

    // Byte mask: only bytes 0 and 2 change.
    do_write(32'h8000_0010, 32'hAABB_CCDD, 8'h05, "mask");
    do_read(32'h8000_0010, 32'h12BB_56DD, "maskrb");

    // Read response stalled by consumer.
    rd_resp_ready = 1'b0;
    rd_addr       = 32'h8000_0000;
    rd_req_valid  = 1'b1;
    tick();
    rd_req_valid = 1'b0;
    wait_rd(n);
    chk_lat("t3 lat", n, RL);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3 hold valid", 32'(rd_resp_valid), 32'd1);
      chk("t3 hold data", rd_data, 32'hDEAD_BEEF);
      chk("t3 req_ready", 32'(rd_req_ready), 32'd0);
    end
    rd_resp_ready = 1'b1;
    tick();
    chk("t3 released", 32'(rd_resp_valid), 32'd0);
    chk("t3 idle", 32'(rd_req_ready), 32'd1);

    // Alternating grant from reset: R, W, R, W.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      rd_addr      = 32'h8000_0000;
      wr_addr      = 32'h8000_0020;
      wr_data      = 32'h1111_0000 + 32'(i);
      wr_mask      = 8'h0F;
      rd_req_valid = 1'b1;
      wr_req_valid = 1'b1;
      tick();
      rd_req_valid = 1'b0;
      wr_req_valid = 1'b0;
      n = 0;
      while (!rd_resp_valid && !wr_resp_valid && n < 40) begin
        tick();
        n++;
      end
      chk("t4 grant rd", 32'(rd_resp_valid), 32'(i % 2 == 0));
      chk("t4 grant wr", 32'(wr_resp_valid), 32'(i % 2 == 1));
      tick();
    end

    // Reset two cycles into a write: dropped, no commit.
    do_write(32'h8000_0030, 32'hCAFE_F00D, 8'h0F, "pre12");
    do_read(32'h8000_0030, 32'hCAFE_F00D, "pre12rb");
    wr_addr      = 32'h8000_0030;
    wr_data      = 32'h0BAD_BEEF;
    wr_mask      = 8'h0F;
    wr_req_valid = 1'b1;
    tick();
    wr_req_valid = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("t5 wr_resp_valid", 32'(wr_resp_valid), 32'd0);
    chk("t5 rd_data", rd_data, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("t5 mem", dut.mem_q[12], 32'hCAFE_F00D);
    do_read(32'h8000_0030, 32'hCAFE_F00D, "t5rb");

    // Back-to-back reads: latency 1 (1..4 with random delay).
    for (int i = 0; i < 16; i++) begin
      do_read(32'h8000_0000, 32'hDEAD_BEEF, "t6");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
